// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and sizing for the sequential divider
// Contents: FSM state encoding, default operand width, iteration-counter width.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    // Counter must index 0..w-1; guard w=1 so the counter is never zero-width.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
// Ports:
//   rem_in  [WIDTH:0]   partial remainder before this step (always < divisor)
//   bit_in              next dividend bit, MSB first
//   divisor [WIDTH-1:0] unsigned divisor magnitude
//   rem_out [WIDTH:0]   partial remainder after this step
//   q_bit               quotient bit produced by this step
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    // One extra bit on top of the remainder width so the top bit of diff is
    // a clean borrow flag.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {2'b00, divisor};
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed/unsigned restoring divider
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 request a divide (accepted only in IDLE)
//   is_signed             1 = two's-complement, 0 = unsigned
//   dividend, divisor     operands, captured with start
//   busy                  operation in progress
//   done                  one-cycle pulse, results valid from this cycle
//   quotient, remainder   results (held until the next done)
//   div_by_zero           captured divisor was zero
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;       // partial remainder
    logic [WIDTH-1:0] dq;        // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor  : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (dq[WIDTH-1]),
        .divisor (dvsr),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            dq          <= '0;
            dvsr        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dq    <= a_mag;
                        dvsr  <= b_mag;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        busy  <= 1'b1;
                        state <= (divisor == '0) ? DONE : RUN;
                    end
                end

                RUN: begin
                    rem <= rem_next;
                    dq  <= {dq[WIDTH-2:0], q_bit};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    // Magnitude of -2^(W-1) / -1 is 2^(W-1); signs agree so it
                    // is left un-negated and reads back as -2^(W-1).
                    quotient    <= neg_q ? -dq : dq;
                    remainder   <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= DONE;
                end

                DONE: begin
                    if (!done) begin
                        // Divide-by-zero arrives here straight from IDLE with no
                        // pulse yet; issue it now. Negating the magnitude restores
                        // the dividend exactly, including -2^(W-1).
                        quotient    <= '1;
                        remainder   <= neg_r ? -dq : dq;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic. SV '/' and '%' truncate toward zero and the
    // remainder follows the dividend's sign, matching div/divu semantics.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        longint na, nb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            if (s) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
            end else begin
                na = longint'({32'd0, a});
                nb = longint'({32'd0, b});
            end
            q = 32'(na / nb);
            r = 32'(na % nb);
            z = 1'b0;
        end
    endtask

    // Launch one divide; lat counts edges after the start edge until done is
    // first sampled high (sampling at the falling edge before each rising edge).
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, output logic [31:0] q, output logic [31:0] r,
                           output logic z, output int lat);
        logic busy_ok;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        check({name, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    vec_t        vecs[$];
    logic [31:0] gq, gr, eq, er, ra, rb;
    logic        gz, ez, rs;
    int          lat, kk;
    logic        saw_done;

    initial begin
        reset     = 1'b1;
        start     = 1'b1;   // reset must win over start
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("reset_state", {29'd0, busy, done, div_by_zero, quotient, remainder}, 64'd0);

        vecs.push_back('{"u100_7",      32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 34});
        vecs.push_back('{"s_m7_2",      32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34});
        vecs.push_back('{"s_7_m2",      32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 34});
        vecs.push_back('{"u5_0",        32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         1'b1, 2});
        vecs.push_back('{"u100_7_clr",  32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 34});
        vecs.push_back('{"s_min_m1",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, 34});
        vecs.push_back('{"u_max_1",     32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0, 34});
        vecs.push_back('{"s_m5_0",      32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2});
        vecs.push_back('{"u3_10",       32'd3,         32'd10,        1'b0, 32'd0,         32'd3,         1'b0, 34});
        vecs.push_back('{"s_min_1",     32'h8000_0000, 32'd1,         1'b1, 32'h8000_0000, 32'd0,         1'b0, 34});
        vecs.push_back('{"u_max_max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1,         32'd0,         1'b0, 34});

        foreach (vecs[i]) begin
            run_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, gq, gr, gz, lat);
            check({vecs[i].name, "_q"},   64'(gq),  64'(vecs[i].q));
            check({vecs[i].name, "_r"},   64'(gr),  64'(vecs[i].r));
            check({vecs[i].name, "_dbz"}, 64'(gz),  64'(vecs[i].z));
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
        end

        // Results hold while idle.
        repeat (3) @(negedge clk);
        check("hold_q", 64'(quotient), 64'd1);
        check("hold_r", 64'(remainder), 64'd0);

        // Randomized operands against the reference model.
        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            ref_div(ra, rb, rs, eq, er, ez);
            run_div("rand", ra, rb, rs, gq, gr, gz, lat);
            check("rand_q",   64'(gq),  64'(eq));
            check("rand_r",   64'(gr),  64'(er));
            check("rand_dbz", 64'(gz),  64'(ez));
            check("rand_lat", 64'(lat), (rb == 32'd0) ? 64'd2 : 64'd34);
        end

        // Start pulses while busy and in DONE must be ignored.
        run_div("pre", 32'd50, 32'd5, 1'b0, gq, gr, gz, lat);
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 32'd7; divisor = 32'd0; is_signed = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        kk = 5;
        check("stale_q_while_busy", 64'(quotient), 64'd10);
        while (!done && kk < 100) begin
            @(negedge clk);
            kk++;
        end
        check("busy_start_lat", 64'(kk), 64'd34);
        check("busy_start_q",   64'(quotient), 64'd333);
        check("busy_start_r",   64'(remainder), 64'd1);
        check("busy_start_dbz", 64'(div_by_zero), 64'd0);
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;   // lands while in DONE
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("done_start_ignored_busy", 64'(busy), 64'd0);
        check("done_start_ignored_q",    64'(quotient), 64'd333);

        // Reset at edge 10 of a divide aborts it with no done pulse.
        @(negedge clk);
        dividend = 32'hDEAD_BEEF; divisor = 32'h1234; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_outputs", {29'd0, busy, done, div_by_zero, quotient, remainder}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        run_div("after_abort", 32'd100, 32'd7, 1'b0, gq, gr, gz, lat);
        check("after_abort_q",   64'(gq),  64'd14);
        check("after_abort_r",   64'(gr),  64'd2);
        check("after_abort_lat", 64'(lat), 64'd34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one clock, `clk`; reset is synchronous and active-high, port `reset`.
REQ-002 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a divide; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = two's-complement (div), 0 = unsigned (divu); captured with start.
REQ-007 dividend  input  WIDTH  numerator; captured with start.
REQ-008 divisor  input  WIDTH  denominator; captured with start.
REQ-009 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-010 done  output  1  one-cycle pulse; results valid from this cycle.
REQ-011 quotient  output  WIDTH  result destined for LO.
REQ-012 remainder  output  WIDTH  result destined for HI.
REQ-013 div_by_zero  output  1  set with done when the captured divisor was 0.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FIX and DONE.
REQ-015 IDLE: start=1 captures operands and goes to RUN (divisor nonzero) or DONE (divisor zero).
REQ-016 On capture, in signed mode, the block SHALL convert the operands to unsigned magnitudes and latch both sign bits.
REQ-017 RUN: one restoring step per cycle, shifting in one dividend bit MSB first, subtracting, and keeping the result only if it is non-negative; exactly WIDTH cycles, counter 0..WIDTH-1, then FIX.
REQ-018 FIX: quotient SHALL be negated if the operand signs differ (signed mode only), and remainder SHALL take the dividend's sign; then DONE.
REQ-019 DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
REQ-020 Latency: done SHALL first be high WIDTH+2 rising edges after the edge that sampled start (34 for WIDTH=32); divide-by-zero: 2 edges.
REQ-021 Divide by zero SHALL give quotient={WIDTH{1}}, remainder=dividend as captured, div_by_zero=1.
REQ-022 Signed -2^(WIDTH-1) / -1 SHALL give quotient=0x80000000 and remainder=0, with no exception flag.
REQ-023 start while busy, or in DONE, SHALL be ignored, with no effect on the operation in progress.
REQ-024 quotient, remainder and div_by_zero SHALL hold their values from done until the next accepted start, then hold stale values until the next done.
REQ-025 Internal width: the partial remainder register SHALL be WIDTH+1 bits to hold the borrow; the quotient is built in place in the dividend shift register.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE and clear busy, done, quotient, remainder, div_by_zero and the iteration counter to 0.
REQ-027 Reset SHALL take priority over start and abort any operation mid-RUN/FIX, producing no done pulse.
REQ-028 The first cycle after reset deasserts SHALL accept start normally.

Structure
REQ-029 A shared package SHALL hold the state encoding (2-bit, IDLE=0, RUN=1, FIX=2, DONE=3), WIDTH, and the iteration-count width $clog2(WIDTH).
REQ-030 One combinational sub-module, div_step, SHALL implement a single restoring iteration: inputs are the partial remainder, the next dividend bit and the divisor; outputs are the new partial remainder and the quotient bit.
REQ-031 All other logic SHALL reside in seq_divider; no multi-cycle combinational paths.

Verification
REQ-032 Unsigned: dividend=100, divisor=7, is_signed=0 -> quotient=14, remainder=2, done at edge 34, busy high for edges 1-33.
REQ-033 Signed: -7 (0xFFFFFFF9) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-034 Zero divisor: 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done at edge 2; the next start clears div_by_zero at its done.
REQ-035 Overflow/limits: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-036 Control: assert reset at edge 10 of a divide, then no done and all outputs 0; a new start 100/7 completes correctly; start pulses during busy change nothing.
